// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_pkg
// Shared FSM state encoding and default data-RAM latency for the controller.
// Revision: 1.0
// ============================================================================
package pipe_hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam int C_RAM_LAT_DEFAULT = 3;
   localparam int C_STALL_W         = 16;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_if
// Pipeline-to-hazard-controller signal bundle: ID/EX status in, enables out.
// Revision: 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 3
);
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_is_load;
   logic                  ex_mem_req;
   logic                  branch_taken;
   logic                  pc_en;
   logic                  if_id_en;
   logic                  id_ex_en;
   logic                  exe_mem_wb_en;
   logic                  if_id_flush;
   logic                  id_ex_flush;
   logic [15:0]           stall_cycles;

   // Pipeline side
   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      output ex_rd, ex_is_load, ex_mem_req, branch_taken,
      input  pc_en, if_id_en, id_ex_en, exe_mem_wb_en,
      input  if_id_flush, id_ex_flush, stall_cycles
   );

   // Controller side
   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      input  ex_rd, ex_is_load, ex_mem_req, branch_taken,
      output pc_en, if_id_en, id_ex_en, exe_mem_wb_en,
      output if_id_flush, id_ex_flush, stall_cycles
   );
endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// load_use_detect
// Combinational load-use hazard detector: an ID source reads the EX load dest.
// Revision: 1.0
// ============================================================================
module load_use_detect #(
   parameter int REG_ADDR_W = 3
) (
   input  wire logic [REG_ADDR_W-1:0] i_id_rs1,
   input  wire logic [REG_ADDR_W-1:0] i_id_rs2,
   input  wire logic                  i_id_rs1_used,
   input  wire logic                  i_id_rs2_used,
   input  wire logic [REG_ADDR_W-1:0] i_ex_rd,
   input  wire logic                  i_ex_is_load,
   output logic                       o_hit
);
   logic w_rs1_match;
   logic w_rs2_match;

   assign w_rs1_match = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
   assign w_rs2_match = i_id_rs2_used && (i_id_rs2 == i_ex_rd);

   // Register 0 is hardwired, so a load targeting it never creates a hazard
   assign o_hit = i_ex_is_load && (i_ex_rd != '0) && (w_rs1_match || w_rs2_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl
// Pipeline hazard controller: RAM-latency freeze, branch flush, load-use stall.
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RAM_LAT    = C_RAM_LAT_DEFAULT,
   parameter int REG_ADDR_W = 3
) (
   input  wire logic        clk,
   input  wire logic        reset,
   pipe_hazard_ctrl_if.slave hz
);
   localparam bit         C_FREEZE_EN = (RAM_LAT > 1);
   localparam logic [3:0] C_WAIT_LOAD = 4'((RAM_LAT > 2) ? (RAM_LAT - 2) : 0);

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        served_q, served_d;
   logic [15:0] stall_q, stall_d;

   logic w_hit;
   logic w_pc_en, w_if_id_en, w_id_ex_en, w_exe_mem_wb_en;
   logic w_if_id_flush, w_id_ex_flush;

   load_use_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_detect (
      .i_id_rs1      (hz.id_rs1),
      .i_id_rs2      (hz.id_rs2),
      .i_id_rs1_used (hz.id_rs1_used),
      .i_id_rs2_used (hz.id_rs2_used),
      .i_ex_rd       (hz.ex_rd),
      .i_ex_is_load  (hz.ex_is_load),
      .o_hit         (w_hit)
   );

   always_comb begin
      state_d         = state_q;
      wait_cnt_d      = wait_cnt_q;
      served_d        = served_q;
      w_pc_en         = 1'b1;
      w_if_id_en      = 1'b1;
      w_id_ex_en      = 1'b1;
      w_exe_mem_wb_en = 1'b1;
      w_if_id_flush   = 1'b0;
      w_id_ex_flush   = 1'b0;

      case (state_q)
         RUN: begin
            served_d = 1'b0;
            if (C_FREEZE_EN && hz.ex_mem_req && !served_q) begin
               w_pc_en         = 1'b0;
               w_if_id_en      = 1'b0;
               w_id_ex_en      = 1'b0;
               w_exe_mem_wb_en = 1'b0;
               // With a two-cycle RAM the freeze cycle alone covers the wait
               if (C_WAIT_LOAD == 4'd0) begin
                  served_d = 1'b1;
               end else begin
                  state_d    = MEM_WAIT;
                  wait_cnt_d = C_WAIT_LOAD;
               end
            end else if (hz.branch_taken) begin
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (w_hit) begin
               w_pc_en       = 1'b0;
               w_if_id_en    = 1'b0;
               w_id_ex_flush = 1'b1;
            end
         end
         MEM_WAIT: begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_exe_mem_wb_en = 1'b0;
            wait_cnt_d      = wait_cnt_q - 4'd1;
            if (wait_cnt_q <= 4'd1) begin
               state_d    = RUN;
               wait_cnt_d = 4'd0;
               served_d   = 1'b1;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 4'd0;
            served_d   = 1'b0;
         end
      endcase

      if (reset) begin
         w_pc_en         = 1'b0;
         w_if_id_en      = 1'b0;
         w_id_ex_en      = 1'b0;
         w_exe_mem_wb_en = 1'b0;
         w_if_id_flush   = 1'b0;
         w_id_ex_flush   = 1'b0;
      end

      stall_d = stall_q;
      if (!w_pc_en && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         wait_cnt_q <= 4'd0;
         served_q   <= 1'b0;
         stall_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         served_q   <= served_d;
         stall_q    <= stall_d;
      end
   end

   assign hz.pc_en         = w_pc_en;
   assign hz.if_id_en      = w_if_id_en;
   assign hz.id_ex_en      = w_id_ex_en;
   assign hz.exe_mem_wb_en = w_exe_mem_wb_en;
   assign hz.if_id_flush   = w_if_id_flush;
   assign hz.id_ex_flush   = w_id_ex_flush;
   assign hz.stall_cycles  = stall_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl
// Directed vector bench for pipe_hazard_ctrl with RAM_LAT = 3.
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

   typedef struct {
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic       u1;
      logic       u2;
      logic [2:0] rd;
      logic       ld;
      logic       mem;
      logic       br;
      logic [5:0] exp;   // {pc_en, if_id_en, id_ex_en, exe_mem_wb_en, if_id_flush, id_ex_flush}
   } vec_t;

   localparam logic [5:0] C_RUN    = 6'b111100;
   localparam logic [5:0] C_FROZEN = 6'b000000;
   localparam logic [5:0] C_BRANCH = 6'b111111;
   localparam logic [5:0] C_LU     = 6'b001101;
   localparam int         C_NVEC   = 10;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   exp_stall;
   vec_t vecs [C_NVEC];
   vec_t idle;

   pipe_hazard_ctrl_if #(.REG_ADDR_W(3)) hz ();

   pipe_hazard_ctrl #(
      .RAM_LAT    (3),
      .REG_ADDR_W (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   logic [5:0] w_out;
   assign w_out = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.exe_mem_wb_en,
                   hz.if_id_flush, hz.id_ex_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input vec_t v);
      hz.id_rs1       = v.rs1;
      hz.id_rs2       = v.rs2;
      hz.id_rs1_used  = v.u1;
      hz.id_rs2_used  = v.u2;
      hz.ex_rd        = v.rd;
      hz.ex_is_load   = v.ld;
      hz.ex_mem_req   = v.mem;
      hz.branch_taken = v.br;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Apply one cycle of stimulus, check outputs and counter before the next edge
   task automatic step(input string name, input vec_t v);
      @(negedge clk);
      drive(v);
      #2;
      chk({name, " out"}, {10'd0, w_out}, {10'd0, v.exp});
      chk({name, " stall"}, hz.stall_cycles, exp_stall[15:0]);
      if (!v.exp[5]) exp_stall++;
   endtask

   function automatic vec_t mk(input logic mem, input logic br, input logic ld,
                               input logic [2:0] rd, input logic [2:0] rs1,
                               input logic u1, input logic [5:0] exp);
      vec_t v;
      v = '{rs1: rs1, rs2: 3'd6, u1: u1, u2: 1'b0, rd: rd, ld: ld,
            mem: mem, br: br, exp: exp};
      return v;
   endfunction

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      exp_stall = 0;
      idle = '{rs1: 3'd0, rs2: 3'd0, u1: 1'b0, u2: 1'b0, rd: 3'd0,
               ld: 1'b0, mem: 1'b0, br: 1'b0, exp: C_RUN};

      vecs[0] = idle;
      vecs[1] = '{3'd5, 3'd1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, C_LU};
      vecs[2] = '{3'd2, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, C_LU};
      vecs[3] = '{3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, C_RUN};
      vecs[4] = '{3'd5, 3'd3, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, C_RUN};
      vecs[5] = '{3'd5, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, C_RUN};
      vecs[6] = '{3'd1, 3'd2, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, C_BRANCH};
      vecs[7] = '{3'd5, 3'd1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, C_BRANCH};
      vecs[8] = '{3'd7, 3'd7, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, C_LU};
      vecs[9] = '{3'd2, 3'd4, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, C_RUN};

      // Reset: everything disabled while asserted, then RUN defaults
      reset = 1'b1;
      drive(idle);
      @(negedge clk);
      #2;
      chk("reset out", {10'd0, w_out}, {10'd0, C_FROZEN});
      @(negedge clk);
      reset = 1'b0;
      #2;
      chk("post-reset out", {10'd0, w_out}, {10'd0, C_RUN});
      chk("post-reset stall", hz.stall_cycles, 16'd0);

      for (int i = 0; i < C_NVEC; i++) begin
         step($sformatf("vec%0d", i), vecs[i]);
      end

      // RAM access: two frozen cycles, released on the third
      step("mem f1", mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, C_FROZEN));
      step("mem f2", mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, C_FROZEN));
      step("mem rel", mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, C_RUN));
      step("mem after", idle);

      // RAM access with a branch pending: flushes only on release
      step("mbr f1", mk(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, C_FROZEN));
      step("mbr f2", mk(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, C_FROZEN));
      step("mbr rel", mk(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, C_BRANCH));

      // Load-use present during a freeze: the stall happens on release
      step("mlu f1", mk(1'b1, 1'b0, 1'b1, 3'd4, 3'd4, 1'b1, C_FROZEN));
      step("mlu f2", mk(1'b1, 1'b0, 1'b1, 3'd4, 3'd4, 1'b1, C_FROZEN));
      step("mlu rel", mk(1'b1, 1'b0, 1'b1, 3'd4, 3'd4, 1'b1, C_LU));
      step("mlu after", idle);

      // Reset during the first wait cycle abandons the freeze
      step("rst f1", mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, C_FROZEN));
      @(negedge clk);
      reset = 1'b1;
      drive(idle);
      #2;
      chk("rst wait out", {10'd0, w_out}, {10'd0, C_FROZEN});
      exp_stall = 0;
      @(negedge clk);
      reset = 1'b0;
      #2;
      chk("rst rel out", {10'd0, w_out}, {10'd0, C_RUN});
      chk("rst rel stall", hz.stall_cycles, 16'd0);
      step("rst idle", idle);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
